lcd_wb_port: RTL and testbench
==============================

Name: lcd_wb_port

Overview:
- Wishbone responder for the MCU's Wishbone initiator port (adr/dat/we/stb/ack); converts single-word bus accesses into 8080-style LCD bus cycles (CSX/DCX/WRX/RDX, 8-bit data).
- Sits beside other responders on the same bus; dat_o is zero when not selected, so it can be OR-combined with other responders' read data.
- Inserts wait states (ack delayed) for the LCD strobe timing, which is programmable at run time.

Parameters:
- BASE_ADR, 15'h0040, word address of register 0; the block decodes adr_i[14:2] == BASE_ADR[14:2].
- T_LO_INIT, 4, reset value of strobe-low extension (0..15).
- T_HI_INIT, 4, reset value of strobe-high/hold extension (0..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active high
- adr_i  in  15  Wishbone word address
- dat_i  in  32  Wishbone write data
- dat_o  out  32  Wishbone read data; 0 unless acking this block's read
- we_i  in  1  write enable
- stb_i  in  1  strobe; the initiator holds it until ack_o
- ack_o  out  1  one-cycle acknowledge
- lcd_di  in  8  LCD data-bus input
- lcd_do  out  8  LCD data-bus output
- lcd_oe  out  1  LCD data-bus output enable (tri-state control lives outside this block)
- lcd_cs, lcd_rs, lcd_wr, lcd_rd  out  1  CSX, DCX, WRX, RDX, all active low except rs
- lcd_rst  out  1  LCD RESET pin, active low

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active high.
- Reset values: ack_o=0, dat_o=0, lcd_do=0, lcd_oe=0, lcd_cs=1, lcd_wr=1, lcd_rd=1, lcd_rs=0, lcd_rst=0 (display held in reset).
- Register map, selected by adr_i[1:0]:
  - 0: W = command byte dat_i[7:0] (rs=0). R = status: bit0 busy (always 0 when read, since the bus is serialised), bit1 lcd_rst level.
  - 1: W = data byte (rs=1). R = LCD read cycle (rs=1), returns the byte in dat_o[7:0].
  - 2: control, R/W. bit0 drives lcd_rst; reset value 0.
  - 3: timing, R/W. [3:0] T_LO, [7:4] T_HI.
- Unused read bits are 0.
- FSM states: IDLE, SETUP, STRB, HOLD, ACK.
- IDLE:
  - On stb_i with an address match, latch we_i, dat_i[7:0] and adr_i[1:0].
  - Register 2/3 access, or register 0 read: go to ACK. ack_o rises on the next clock (1-cycle latency).
  - Register 0/1 write, or register 1 read: go to SETUP.
- SETUP (1 clock): lcd_cs=0, lcd_rs set; for writes lcd_do=byte and lcd_oe=1.
- STRB (T_LO+1 clocks): lcd_wr=0 (write) or lcd_rd=0 (read). Reads capture lcd_di on the final STRB clock edge.
- HOLD (T_HI+1 clocks): strobes high; cs stays low and write data stays driven.
- ACK (1 clock):
  - ack_o=1; lcd_cs=1 and lcd_oe=0 on entry.
  - dat_o holds read data during this clock only, 0 otherwise.
  - Then return to IDLE.
- LCD access latency: ack_o is high in clock T_LO+T_HI+4 after the stb_i sampling edge (defaults 4/4 → clock 12).
- Counter: 4-bit, reloaded on each state entry. T_LO/T_HI are sampled at SETUP entry, so a timing write never affects an in-flight cycle.
- stb_i dropped mid-cycle:
  - The LCD cycle still completes.
  - ACK is skipped if stb_i is low in that clock; the FSM returns to IDLE.
- Back-to-back: a new stb_i is accepted only in IDLE. The minimum gap between consecutive accesses is the 1 clock after ACK.
- Address mismatch: no response, ack_o stays 0, and dat_o stays 0.
- rst asserted mid-cycle: outputs return to reset values immediately; the timing register returns to its INIT values.

Decomposition:
- Shared package: register offsets (REG_CMD=0, REG_DATA=1, REG_CTRL=2, REG_TIME=3), FSM state encoding, status bit positions.
- No sub-module is needed; the strobe counter is inline.

Test Plan:
- Reset: assert rst → lcd_cs=lcd_wr=lcd_rd=1, lcd_rst=0, ack_o=0, timing reads 8'h44.
- Write REG_CTRL=1 → ack_o one clock after stb_i, lcd_rst=1; read REG_CMD → dat_o=32'h2.
- Write command 8'h2C with defaults:
  - lcd_rs=0, lcd_do=8'h2C, lcd_oe=1;
  - lcd_wr low exactly 5 clocks; cs low from SETUP through HOLD;
  - ack_o in clock 12 after stb_i, single cycle.
- Write REG_TIME=8'h10, then read REG_DATA with lcd_di=8'hA5 → rd low 1 clock, hold 2 clocks, dat_o=32'h000000A5 during ack in clock 5.
- Access at BASE_ADR+4 (no match) → no ack; dat_o=0 for 20 clocks.
- Pulse rst during STRB of a data write → lcd_wr and lcd_cs return high immediately; the next write completes normally with default timing.

Source files
------------

// File: rtl/lcd_wb_port_pkg.sv
// Shared definitions for the Wishbone-to-8080 LCD port: register offsets,
// FSM state encoding and status bit positions.
package lcd_wb_port_pkg;

    localparam logic [1:0] REG_CMD  = 2'd0;
    localparam logic [1:0] REG_DATA = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam logic [1:0] REG_TIME = 2'd3;

    localparam int STAT_BUSY = 0;
    localparam int STAT_RST  = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STRB,
        S_HOLD,
        S_ACK
    } state_t;

endpackage

// File: rtl/lcd_wb_port.sv
// Wishbone responder that turns single-word accesses into 8080-style LCD bus
// cycles, stretching ack_o by a run-time programmable strobe timing.
module lcd_wb_port
    import lcd_wb_port_pkg::*;
#(
    parameter logic [14:0] BASE_ADR  = 15'h0040,
    parameter logic [3:0]  T_LO_INIT = 4'd4,
    parameter logic [3:0]  T_HI_INIT = 4'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [14:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        we_i,
    input  logic        stb_i,
    output logic        ack_o,
    input  logic [7:0]  lcd_di,
    output logic [7:0]  lcd_do,
    output logic        lcd_oe,
    output logic        lcd_cs,
    output logic        lcd_rs,
    output logic        lcd_wr,
    output logic        lcd_rd,
    output logic        lcd_rst
);

    state_t      state;
    logic [3:0]  cnt;
    logic [3:0]  t_lo, t_hi;
    logic [3:0]  lo_l, hi_l;
    logic        we_l;
    logic [7:0]  rd_byte;
    logic        sel;
    logic        direct;
    logic [31:0] reg_rdata;

    // Only the low byte of a write ever reaches the LCD or a register.
    logic unused_dat;
    assign unused_dat = ^dat_i[31:8];

    assign sel = stb_i && (adr_i[14:2] == BASE_ADR[14:2]);

    // Control/timing registers and status reads complete without an LCD cycle.
    assign direct = adr_i[1] || (adr_i[1:0] == REG_CMD && !we_i);

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        reg_rdata = '0;
        case (adr_i[1:0])
            REG_CMD:  reg_rdata[STAT_RST] = lcd_rst;
            REG_CTRL: reg_rdata[0]        = lcd_rst;
            REG_TIME: reg_rdata[7:0]      = {t_hi, t_lo};
            default:  reg_rdata           = '0;
        endcase
    end

    // NOTE: all state and outputs use non-blocking assignments so every update lands on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            t_lo    <= T_LO_INIT;
            t_hi    <= T_HI_INIT;
            lo_l    <= '0;
            hi_l    <= '0;
            we_l    <= 1'b0;
            rd_byte <= '0;
            ack_o   <= 1'b0;
            dat_o   <= '0;
            lcd_do  <= '0;
            lcd_oe  <= 1'b0;
            lcd_cs  <= 1'b1;
            lcd_rs  <= 1'b0;
            lcd_wr  <= 1'b1;
            lcd_rd  <= 1'b1;
            lcd_rst <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ack_o <= 1'b0;
                    dat_o <= '0;
                    if (sel) begin
                        we_l <= we_i;
                        if (direct) begin
                            state <= S_ACK;
                            ack_o <= 1'b1;
                            dat_o <= we_i ? 32'd0 : reg_rdata;
                            if (we_i && adr_i[1:0] == REG_CTRL)
                                lcd_rst <= dat_i[0];
                            if (we_i && adr_i[1:0] == REG_TIME) begin
                                t_lo <= dat_i[3:0];
                                t_hi <= dat_i[7:4];
                            end
                        end else begin
                            state  <= S_SETUP;
                            lcd_cs <= 1'b0;
                            lcd_rs <= (adr_i[1:0] == REG_DATA);
                            lo_l   <= t_lo;
                            hi_l   <= t_hi;
                            if (we_i) begin
                                lcd_do <= dat_i[7:0];
                                lcd_oe <= 1'b1;
                            end
                        end
                    end
                end
                S_SETUP: begin
                    state <= S_STRB;
                    cnt   <= lo_l;
                    if (we_l) lcd_wr <= 1'b0;
                    else      lcd_rd <= 1'b0;
                end
                S_STRB: begin
                    if (cnt == 4'd0) begin
                        state  <= S_HOLD;
                        cnt    <= hi_l;
                        lcd_wr <= 1'b1;
                        lcd_rd <= 1'b1;
                        if (!we_l) rd_byte <= lcd_di;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_HOLD: begin
                    if (cnt == 4'd0) begin
                        lcd_cs <= 1'b1;
                        lcd_oe <= 1'b0;
                        // An initiator that gave up mid-cycle gets no acknowledge.
                        if (stb_i) begin
                            state <= S_ACK;
                            ack_o <= 1'b1;
                            dat_o <= we_l ? 32'd0 : {24'd0, rd_byte};
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                    ack_o <= 1'b0;
                    dat_o <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_wb_port.sv
// Randomised self-checking bench for lcd_wb_port against a transaction-level
// model of the register file and the LCD cycle timing.
module tb_lcd_wb_port;
    import lcd_wb_port_pkg::*;

    localparam logic [14:0] BASE = 15'h0040;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] adr_i;
    logic [31:0] dat_i, dat_o;
    logic        we_i, stb_i, ack_o;
    logic [7:0]  lcd_di, lcd_do;
    logic        lcd_oe, lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_rst;

    lcd_wb_port dut (
        .clk(clk), .rst(rst), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
        .we_i(we_i), .stb_i(stb_i), .ack_o(ack_o), .lcd_di(lcd_di), .lcd_do(lcd_do),
        .lcd_oe(lcd_oe), .lcd_cs(lcd_cs), .lcd_rs(lcd_rs), .lcd_wr(lcd_wr),
        .lcd_rd(lcd_rd), .lcd_rst(lcd_rst)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int   m_lo, m_hi;
    logic m_ctrl;

    // Observations of one access
    logic        got_ack;
    int          lat, ack_cycles, wr_lo, rd_lo, cs_lo, do_bad, rs_bad, oe_bad, dat_bad;
    logic [31:0] rd_val;
    logic [7:0]  exp_byte;
    logic        exp_rs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Drives one bus access from a negedge and observes every clock until
    // one clock past ack, or until the clock budget runs out.
    task automatic access(input logic [14:0] adr, input logic we, input logic [31:0] wd,
                          input logic [7:0] di, input int limit, input int drop);
        logic rd_prev;
        got_ack = 0; lat = 0; ack_cycles = 0; wr_lo = 0; rd_lo = 0; cs_lo = 0;
        do_bad = 0; rs_bad = 0; oe_bad = 0; dat_bad = 0; rd_val = '0;
        rd_prev = 1'b1;
        adr_i = adr; we_i = we; dat_i = wd; lcd_di = di; stb_i = 1'b1;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            if (drop > 0 && n == drop) stb_i = 1'b0;
            if (ack_o) begin
                ack_cycles++;
                if (!got_ack) begin
                    got_ack = 1; lat = n; rd_val = dat_o; stb_i = 1'b0;
                end
            end else if (dat_o != 32'd0) dat_bad++;
            if (!lcd_wr) begin
                wr_lo++;
                if (lcd_do != exp_byte || !lcd_oe) do_bad++;
            end
            if (!lcd_rd) begin
                rd_lo++;
                if (lcd_oe) oe_bad++;
            end
            if (!lcd_cs) begin
                cs_lo++;
                if (lcd_rs != exp_rs) rs_bad++;
            end
            if (lcd_cs && lcd_oe) oe_bad++;
            // Change the bus once the read strobe has ended; a late capture would see it.
            if (!rd_prev && lcd_rd) lcd_di = ~di;
            rd_prev = lcd_rd;
            if (got_ack && n == lat + 1) break;
        end
        stb_i = 1'b0;
    endtask

    task automatic run_txn(input logic [1:0] r, input logic w, input logic [31:0] wd,
                           input logic [7:0] di, input int drop);
        logic        lcd_acc;
        int          exp_lat;
        logic [31:0] exp_rd;
        lcd_acc  = (r == REG_DATA) || (r == REG_CMD && w);
        exp_lat  = lcd_acc ? m_lo + m_hi + 4 : 1;
        exp_byte = wd[7:0];
        exp_rs   = (r == REG_DATA);
        case (r)
            REG_CMD:  exp_rd = {30'd0, m_ctrl, 1'b0};
            REG_DATA: exp_rd = {24'd0, di};
            REG_CTRL: exp_rd = {31'd0, m_ctrl};
            default:  exp_rd = m_hi * 16 + m_lo;
        endcase
        if (w) exp_rd = 32'd0;
        access(BASE | {13'd0, r}, w, wd, di, (drop > 0) ? 40 : 60, drop);
        if (drop == 0) begin
            check($sformatf("ack r%0d", r), {31'd0, got_ack}, 32'd1);
            check($sformatf("latency r%0d w%0d", r, w), lat, exp_lat);
            check($sformatf("ack width r%0d", r), ack_cycles, 32'd1);
            check($sformatf("rdata r%0d w%0d", r, w), rd_val, exp_rd);
        end else begin
            check("dropped stb no ack", {31'd0, got_ack}, 32'd0);
        end
        check("wr low clocks", wr_lo, (lcd_acc && w) ? m_lo + 1 : 0);
        check("rd low clocks", rd_lo, (lcd_acc && !w) ? m_lo + 1 : 0);
        check("cs low clocks", cs_lo, lcd_acc ? m_lo + m_hi + 3 : 0);
        check("lcd_do/oe during wr", do_bad, 0);
        check("rs during cs", rs_bad, 0);
        check("oe misuse", oe_bad, 0);
        check("dat_o zero outside ack", dat_bad, 0);
        if (w && r == REG_CTRL) m_ctrl = wd[0];
        if (w && r == REG_TIME) begin
            m_lo = int'(wd[3:0]);
            m_hi = int'(wd[7:4]);
        end
        check("lcd_rst level", {31'd0, lcd_rst}, {31'd0, m_ctrl});
    endtask

    task automatic run_nomatch(input logic [14:0] adr);
        exp_byte = 8'h00; exp_rs = 1'b0;
        access(adr, 1'b1, 32'h0000_00FF, 8'h00, 20, 0);
        check("nomatch ack", {31'd0, got_ack}, 32'd0);
        check("nomatch dat_o", dat_bad, 0);
        check("nomatch cs", cs_lo, 0);
    endtask

    initial begin
        logic [1:0]  r;
        logic        w;
        logic        lcd_acc;
        logic [14:0] bad_adr;
        logic        seen;

        rst = 1'b1; stb_i = 1'b0; we_i = 1'b0; adr_i = '0; dat_i = '0; lcd_di = '0;
        m_lo = 4; m_hi = 4; m_ctrl = 1'b0;
        repeat (3) @(negedge clk);
        check("reset cs/wr/rd/rst/ack/oe",
              {26'd0, lcd_cs, lcd_wr, lcd_rd, lcd_rst, ack_o, lcd_oe}, {26'd0, 6'b111000});
        check("reset dat_o", dat_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed sequence
        run_txn(REG_TIME, 1'b0, 32'd0, 8'h00, 0);
        run_txn(REG_CTRL, 1'b1, 32'd1, 8'h00, 0);
        run_txn(REG_CMD, 1'b0, 32'd0, 8'h00, 0);
        run_txn(REG_CMD, 1'b1, 32'h0000_002C, 8'h00, 0);
        run_txn(REG_TIME, 1'b1, 32'h0000_0010, 8'h00, 0);
        run_txn(REG_DATA, 1'b0, 32'd0, 8'hA5, 0);
        run_nomatch(BASE + 15'd4);

        // Randomised traffic
        for (int i = 0; i < 40; i++) begin
            r = 2'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            lcd_acc = (r == REG_DATA) || (r == REG_CMD && w);
            run_txn(r, w, $urandom, 8'($urandom),
                    (lcd_acc && $urandom_range(0, 7) == 0) ? 2 : 0);
            if ($urandom_range(0, 9) == 0) begin
                bad_adr = 15'($urandom) ^ {13'd0, 2'($urandom)};
                if (bad_adr[14:2] == BASE[14:2]) bad_adr[14] = ~bad_adr[14];
                run_nomatch(bad_adr);
            end
        end

        // Reset in the middle of a data write strobe
        run_txn(REG_TIME, 1'b1, 32'h0000_0021, 8'h00, 0);
        adr_i = BASE | 15'd1; we_i = 1'b1; dat_i = 32'h55; stb_i = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (!lcd_wr) seen = 1'b1;
        end
        check("wr strobe reached", {31'd0, seen}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid-cycle reset pins",
              {27'd0, lcd_cs, lcd_wr, lcd_rd, ack_o, lcd_oe}, {27'd0, 5'b11100});
        stb_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_lo = 4; m_hi = 4; m_ctrl = 1'b0;
        @(negedge clk);
        run_txn(REG_TIME, 1'b0, 32'd0, 8'h00, 0);
        run_txn(REG_DATA, 1'b1, 32'h0000_0077, 8'h00, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
